// File: rtl/rob_commit_if.sv
// Issue / writeback / commit bundle between a reorder buffer and its neighbours.
// The slave modport is the reorder buffer side.
interface rob_commit_if #(
   parameter int unsigned XLEN = 32
);
   logic            pause;
   logic            flush;
   logic            issue;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic [2:0]      alloc_num;
   logic            wb_valid;
   logic [2:0]      wb_num;
   logic [XLEN-1:0] wb_data;
   logic            commit;
   logic [4:0]      reg_num;
   logic [XLEN-1:0] data_in;
   logic [2:0]      num_in;
   logic [2:0]      count;

   modport master (
      output pause, flush, issue, issue_rd, wb_valid, wb_num, wb_data,
      input  issue_ready, alloc_num, commit, reg_num, data_in, num_in, count
   );

   modport slave (
      input  pause, flush, issue, issue_rd, wb_valid, wb_num, wb_data,
      output issue_ready, alloc_num, commit, reg_num, data_in, num_in, count
   );
endinterface

// File: rtl/rob_commit.sv
// Seven-entry in-order reorder buffer: issues 3-bit tags (entry i owns tag i+1),
// captures results by tag and retires them in program order to the register file.
module rob_commit #(
   parameter int unsigned DEPTH = 7,
   parameter int unsigned XLEN  = 32
) (
   input  logic          clk,
   input  logic          rst,
   rob_commit_if.slave   bus
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_ready;
   logic [4:0]       r_rd    [DEPTH];
   logic [XLEN-1:0]  r_value [DEPTH];
   logic [2:0]       r_head;
   logic [2:0]       r_tail;
   logic [2:0]       r_count;

   logic             r_commit;
   logic [4:0]       r_reg_num;
   logic [XLEN-1:0]  r_data_in;
   logic [2:0]       r_num_in;

   logic             w_issue_ready;
   logic             w_do_issue;
   logic             w_do_commit;
   logic [DEPTH-1:0] w_wb_sel;
   logic [2:0]       w_head_nxt;
   logic [2:0]       w_tail_nxt;

   function automatic logic [2:0] ptr_inc(input logic [2:0] p);
      return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   always_comb begin
      w_issue_ready = (r_count < 3'(DEPTH)) && !bus.pause && !bus.flush;
      w_do_issue    = bus.issue && w_issue_ready;
      w_do_commit   = !bus.pause && !bus.flush && r_busy[r_head] && r_ready[r_head];
      w_head_nxt    = ptr_inc(r_head);
      w_tail_nxt    = ptr_inc(r_tail);
   end

   // Tag 0 never matches an entry, so wb_num==0 drops out of the decode.
   always_comb begin
      w_wb_sel = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_wb_sel[i] = bus.wb_valid && !bus.flush && (bus.wb_num == 3'(i + 1))
                       && r_busy[i] && !r_ready[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy  <= '0;
         r_ready <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_rd[i]    <= '0;
            r_value[i] <= '0;
         end
      end else if (bus.flush) begin
         r_busy  <= '0;
         r_ready <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_do_commit && (r_head == 3'(i))) begin
               r_busy[i]  <= 1'b0;
               r_ready[i] <= 1'b0;
            end
            if (w_do_issue && (r_tail == 3'(i))) begin
               r_busy[i]  <= 1'b1;
               r_ready[i] <= 1'b0;
               r_rd[i]    <= bus.issue_rd;
            end
            if (w_wb_sel[i]) begin
               r_ready[i] <= 1'b1;
               r_value[i] <= bus.wb_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_commit) r_head <= w_head_nxt;
         if (w_do_issue)  r_tail <= w_tail_nxt;
         case ({w_do_issue, w_do_commit})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Retire port: rd==0 entries retire silently but still update the data outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_commit  <= 1'b0;
         r_reg_num <= '0;
         r_data_in <= '0;
         r_num_in  <= '0;
      end else if (w_do_commit) begin
         r_commit  <= (r_rd[r_head] != 5'd0);
         r_reg_num <= r_rd[r_head];
         r_data_in <= r_value[r_head];
         r_num_in  <= r_head + 3'd1;
      end else begin
         r_commit  <= 1'b0;
      end
   end

   assign bus.issue_ready = w_issue_ready;
   assign bus.alloc_num   = r_tail + 3'd1;
   assign bus.commit      = r_commit;
   assign bus.reg_num     = r_reg_num;
   assign bus.data_in     = r_data_in;
   assign bus.num_in      = r_num_in;
   assign bus.count       = r_count;

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit with hand-computed expectations.
module tb_rob_commit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   rob_commit_if #(.XLEN(32)) bus ();

   rob_commit #(.DEPTH(7), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pause    = 1'b0;
      bus.flush    = 1'b0;
      bus.issue    = 1'b0;
      bus.issue_rd = 5'd0;
      bus.wb_valid = 1'b0;
      bus.wb_num   = 3'd0;
      bus.wb_data  = 32'd0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
   endtask

   initial begin
      idle_inputs();
      repeat (2) step();
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_commit", 32'(bus.commit), 32'd0);
      check_eq("rst_data_in", bus.data_in, 32'd0);
      rst = 1'b1;
      repeat (3) step();
      check_eq("idle_count", 32'(bus.count), 32'd0);
      check_eq("idle_commit", 32'(bus.commit), 32'd0);
      check_eq("idle_alloc", 32'(bus.alloc_num), 32'd1);
      check_eq("idle_ready", 32'(bus.issue_ready), 32'd1);

      // Single issue / writeback / commit
      bus.issue = 1'b1; bus.issue_rd = 5'd5;
      check_eq("s_alloc", 32'(bus.alloc_num), 32'd1);
      step();
      bus.issue = 1'b0;
      check_eq("s_count1", 32'(bus.count), 32'd1);
      bus.wb_valid = 1'b1; bus.wb_num = 3'd1; bus.wb_data = 32'hDEADBEEF;
      step();
      bus.wb_valid = 1'b0;
      check_eq("s_no_bypass", 32'(bus.commit), 32'd0);
      step();
      check_eq("s_commit", 32'(bus.commit), 32'd1);
      check_eq("s_reg_num", 32'(bus.reg_num), 32'd5);
      check_eq("s_data_in", bus.data_in, 32'hDEADBEEF);
      check_eq("s_num_in", 32'(bus.num_in), 32'd1);
      check_eq("s_count0", 32'(bus.count), 32'd0);
      step();
      check_eq("s_pulse", 32'(bus.commit), 32'd0);
      check_eq("s_alloc2", 32'(bus.alloc_num), 32'd2);

      // Out-of-order completion, in-order retire
      do_flush();
      check_eq("f_alloc", 32'(bus.alloc_num), 32'd1);
      for (int i = 0; i < 3; i++) begin
         bus.issue = 1'b1; bus.issue_rd = 5'(i + 1);
         check_eq("o_alloc", 32'(bus.alloc_num), 32'(i + 1));
         step();
      end
      bus.issue = 1'b0;
      check_eq("o_count3", 32'(bus.count), 32'd3);
      bus.wb_valid = 1'b1;
      bus.wb_num = 3'd3; bus.wb_data = 32'h0000_0333; step();
      bus.wb_num = 3'd2; bus.wb_data = 32'h0000_0222; step();
      check_eq("o_wait", 32'(bus.commit), 32'd0);
      bus.wb_num = 3'd1; bus.wb_data = 32'h0000_0111; step();
      bus.wb_valid = 1'b0;
      check_eq("o_wait2", 32'(bus.commit), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check_eq("o_commit", 32'(bus.commit), 32'd1);
         check_eq("o_num_in", 32'(bus.num_in), 32'(i));
         check_eq("o_reg_num", 32'(bus.reg_num), 32'(i));
         check_eq("o_data_in", bus.data_in, 32'(i * 32'h111));
      end
      check_eq("o_count0", 32'(bus.count), 32'd0);

      // Fill, full-stall, wrap, issue+commit together
      do_flush();
      for (int i = 0; i < 7; i++) begin
         bus.issue = 1'b1; bus.issue_rd = 5'(i + 1);
         check_eq("w_alloc", 32'(bus.alloc_num), 32'(i + 1));
         step();
      end
      check_eq("w_count7", 32'(bus.count), 32'd7);
      check_eq("w_full_rdy", 32'(bus.issue_ready), 32'd0);
      check_eq("w_alloc_wrap", 32'(bus.alloc_num), 32'd1);
      bus.issue_rd = 5'd20;
      bus.wb_valid = 1'b1; bus.wb_num = 3'd1; bus.wb_data = 32'hA1;
      step();
      check_eq("w_full_ignore", 32'(bus.count), 32'd7);
      bus.wb_num = 3'd2; bus.wb_data = 32'hA2;
      check_eq("w_full_commit_rdy", 32'(bus.issue_ready), 32'd0);
      step();
      bus.wb_valid = 1'b0;
      check_eq("w_c1_commit", 32'(bus.commit), 32'd1);
      check_eq("w_c1_num", 32'(bus.num_in), 32'd1);
      check_eq("w_c1_count", 32'(bus.count), 32'd6);
      bus.issue_rd = 5'd9;
      check_eq("w_rdy_again", 32'(bus.issue_ready), 32'd1);
      check_eq("w_alloc_reuse", 32'(bus.alloc_num), 32'd1);
      step();
      bus.issue = 1'b0;
      check_eq("w_c2_commit", 32'(bus.commit), 32'd1);
      check_eq("w_c2_num", 32'(bus.num_in), 32'd2);
      check_eq("w_c2_data", bus.data_in, 32'hA2);
      check_eq("w_both_count", 32'(bus.count), 32'd6);
      check_eq("w_alloc_next", 32'(bus.alloc_num), 32'd2);

      // rd=0 retires silently
      do_flush();
      bus.issue = 1'b1; bus.issue_rd = 5'd0; step();
      bus.issue = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_num = 3'd1; bus.wb_data = 32'h12345678; step();
      bus.wb_valid = 1'b0;
      step();
      check_eq("z_commit", 32'(bus.commit), 32'd0);
      check_eq("z_num_in", 32'(bus.num_in), 32'd1);
      check_eq("z_data_in", bus.data_in, 32'h12345678);
      check_eq("z_count", 32'(bus.count), 32'd0);

      // Pause, flush, asynchronous reset
      do_flush();
      for (int i = 0; i < 4; i++) begin
         bus.issue = 1'b1; bus.issue_rd = 5'(10 + i); step();
      end
      bus.issue = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_num = 3'd1; bus.wb_data = 32'hB1; step();
      bus.pause = 1'b1;
      bus.wb_num = 3'd2; bus.wb_data = 32'hB2; step();
      bus.wb_valid = 1'b0;
      check_eq("p_rdy", 32'(bus.issue_ready), 32'd0);
      step();
      check_eq("p_commit", 32'(bus.commit), 32'd0);
      check_eq("p_count", 32'(bus.count), 32'd4);
      bus.pause = 1'b0;
      step();
      check_eq("p_c1_commit", 32'(bus.commit), 32'd1);
      check_eq("p_c1_reg", 32'(bus.reg_num), 32'd10);
      check_eq("p_c1_count", 32'(bus.count), 32'd3);
      step();
      check_eq("p_c2_num", 32'(bus.num_in), 32'd2);
      check_eq("p_c2_data", bus.data_in, 32'hB2);
      check_eq("p_c2_count", 32'(bus.count), 32'd2);
      bus.flush = 1'b1; bus.issue = 1'b1; bus.issue_rd = 5'd7;
      bus.wb_valid = 1'b1; bus.wb_num = 3'd3; bus.wb_data = 32'hB3;
      step();
      idle_inputs();
      check_eq("fl_count", 32'(bus.count), 32'd0);
      check_eq("fl_alloc", 32'(bus.alloc_num), 32'd1);
      check_eq("fl_commit", 32'(bus.commit), 32'd0);
      bus.issue = 1'b1; bus.issue_rd = 5'd4; step();
      bus.issue = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_num = 3'd1; bus.wb_data = 32'hC4; step();
      bus.wb_valid = 1'b0;
      step();
      check_eq("r_pre_commit", 32'(bus.commit), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("r_async_commit", 32'(bus.commit), 32'd0);
      check_eq("r_async_num", 32'(bus.num_in), 32'd0);
      check_eq("r_async_count", 32'(bus.count), 32'd0);
      step();
      check_eq("r_hold_data", bus.data_in, 32'd0);
      rst = 1'b1;
      check_eq("r_post_alloc", 32'(bus.alloc_num), 32'd1);
      check_eq("r_post_rdy", 32'(bus.issue_ready), 32'd1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Seven-entry in-order reorder buffer that issues the 3-bit dependency tags consumed by the register file.
- Captures execution results by tag, then retires them in program order.
- Drives the register file's commit interface: commit, reg_num, data_in, num_in.
- Tag 0 means "no dependency"; entry index i (0..6) owns tag i+1.

Parameters:
- DEPTH, 7, number of entries; fixed by the 3-bit tag with 0 reserved.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- pause  input  1  freezes issue and commit; writebacks are still accepted.
- flush  input  1  synchronous clear of all entries (mispredict).
- issue  input  1  allocate one entry this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_ready  output  1  combinational; high when count<7 and !pause and !flush.
- alloc_num  output  3  combinational; tag of the tail entry (tail+1).
- wb_valid  input  1  result broadcast valid.
- wb_num  input  3  tag of the result.
- wb_data  input  32  result value.
- commit  output  1  registered; one-cycle retire-write pulse to the register file.
- reg_num  output  5  registered; destination register of the retiring entry.
- data_in  output  32  registered; value of the retiring entry.
- num_in  output  3  registered; tag of the retiring entry.
- count  output  3  registered; number of occupied entries, 0..7.

Behaviour:
- State per entry: busy, ready, rd[4:0], value[31:0]. Pointers head and tail (0..6, wrap 6->0). count register.
- Reset (rst=0, async):
  - all busy/ready = 0; head = tail = 0; count = 0.
  - commit = 0; reg_num = 0; data_in = 0; num_in = 0.
  - All effects hold until rst returns to 1, including mid-operation.
- Issue, on posedge when issue && issue_ready:
  - entry[tail] gets busy=1, ready=0, rd=issue_rd.
  - tail advances and count increments.
  - alloc_num during that cycle is the tag the issuer must record.
  - issue while !issue_ready is ignored; no state change.
- Writeback, on posedge when wb_valid && wb_num!=0 and entry[wb_num-1] is busy and not ready:
  - value=wb_data, ready=1.
  - Ignored if wb_num=0, the entry is not busy, or the entry is already ready.
  - Accepted regardless of pause.
- Commit, on posedge when !pause && !flush && entry[head] busy && ready (state at the start of the cycle):
  - commit <= (rd!=0); reg_num <= rd; data_in <= value; num_in <= head+1.
  - entry[head] busy <= 0; head advances; count decrements.
  - rd=0 entries retire silently: commit=0, and reg_num/data_in/num_in still update.
  - Otherwise commit <= 0 and the other commit outputs hold.
  - At most one retire per cycle.
- Latency:
  - A writeback at edge N makes the entry ready after N.
  - If that entry is head, commit is high in the cycle after edge N+1.
  - No wb-to-commit bypass.
- Simultaneous events:
  - Issue plus commit in the same cycle: count unchanged; both pointers advance.
  - Full (count=7): issue_ready=0 even if a commit happens this cycle.
  - Writeback to the head entry in the same cycle as a commit check: commit waits a cycle.
- Flush (sync, rst=1):
  - all busy/ready cleared; head = tail = 0; count = 0; commit <= 0.
  - Overrides issue, writeback and commit in that cycle.
- Pause: issue and commit suppressed; commit <= 0; pointers and count held.
- Empty (count=0): commit stays 0 and head stays put.
- Wrap: after tag 7 is issued, the next alloc_num is 1.

Test Plan:
- Reset then idle 3 cycles -> count=0, commit=0, alloc_num=1, issue_ready=1.
- Issue rd=5 (tag 1), wb tag1 data 0xDEADBEEF -> the cycle after the next edge shows commit=1, reg_num=5, data_in=0xDEADBEEF, num_in=1; count returns to 0.
- Out-of-order completion: issue rd 1,2,3 (tags 1..3), write back tag3 then tag2 then tag1 -> commits appear in order with num_in=1,2,3 on consecutive cycles.
- Issue 7 entries -> count=7, issue_ready=0. A further issue is ignored. Retire tag 1 while issuing -> the new entry takes alloc_num=1 (wrap).
- Issue rd=0 as tag 1, write it back -> count drops to 0, commit stays 0, num_in=1.
- Mid-operation: with 4 entries busy, assert pause with a ready head -> no commit while paused, and a writeback during pause is still captured. Assert flush -> count=0, alloc_num=1. Drop rst asynchronously mid-cycle -> commit=0 immediately.
